// File: rtl/instr_cache_direct.sv
// Direct-mapped instruction cache between the fetch stage and instruction memory.
// Hits are served combinationally; misses refill a whole line through a req/ack beat handshake.
module instr_cache_direct #(
  parameter int SETS_LOG2  = 8,
  parameter int WORDS_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic        req,
  output logic [31:0] rd,
  output logic        hit,
  output logic        stall,
  input  logic        inval,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd
);

  localparam int TAG_W  = 30 - SETS_LOG2 - WORDS_LOG2;
  localparam int LINE_W = 30 - WORDS_LOG2;
  localparam int NSETS  = 1 << SETS_LOG2;
  localparam int NWORDS = 1 << (SETS_LOG2 + WORDS_LOG2);
  localparam logic [WORDS_LOG2-1:0] LAST_BEAT = '1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [31:0]           r_data [NWORDS];
  logic [TAG_W-1:0]      r_tag  [NSETS];
  logic [NSETS-1:0]      r_valid;
  logic [LINE_W-1:0]     r_line;
  logic [WORDS_LOG2-1:0] r_cnt;
  logic                  r_mem_req;
  logic [31:0]           r_mem_addr;
  logic                  r_inval_pend;

  logic [WORDS_LOG2-1:0] w_offset;
  logic [SETS_LOG2-1:0]  w_set;
  logic [TAG_W-1:0]      w_tag;
  logic [SETS_LOG2-1:0]  w_fill_set;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_lookup_hit;
  logic                  w_start;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_unused_a;

  assign w_offset   = a[WORDS_LOG2+1:2];
  assign w_set      = a[SETS_LOG2+WORDS_LOG2+1:WORDS_LOG2+2];
  assign w_tag      = a[31:SETS_LOG2+WORDS_LOG2+2];
  assign w_unused_a = ^a[1:0];
  assign w_fill_set = r_line[SETS_LOG2-1:0];
  assign w_fill_tag = r_line[LINE_W-1:SETS_LOG2];

  assign w_lookup_hit = r_valid[w_set] && (r_tag[w_set] == w_tag);
  assign w_start      = (r_state == IDLE) && req && !w_lookup_hit;
  assign w_beat       = (r_state == FILL) && mem_ack;
  assign w_last       = w_beat && (r_cnt == LAST_BEAT);

  // Hits are only reported from IDLE so a line never looks valid mid-refill.
  assign hit      = req && w_lookup_hit && (r_state == IDLE);
  assign stall    = req && !hit;
  assign rd       = r_data[{w_set, w_offset}];
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = FILL;
      FILL:    if (w_last)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // An invalidate seen during a refill leaves that line invalid when the refill lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= '0;
      r_line       <= '0;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_inval_pend <= 1'b0;
    end else begin
      if (inval) r_valid <= '0;
      if ((r_state == FILL) && inval) r_inval_pend <= 1'b1;
      if (w_start) begin
        r_line     <= a[31:WORDS_LOG2+2];
        r_cnt      <= '0;
        r_mem_req  <= 1'b1;
        r_mem_addr <= {a[31:WORDS_LOG2+2], {(WORDS_LOG2+2){1'b0}}};
      end
      if (w_beat) begin
        r_cnt      <= r_cnt + WORDS_LOG2'(1);
        r_mem_addr <= r_mem_addr + 32'd4;
      end
      if (w_last) begin
        r_valid[w_fill_set] <= ~(r_inval_pend | inval);
        r_inval_pend        <= 1'b0;
        r_mem_req           <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) r_data[{w_fill_set, r_cnt}] <= mem_rd;
    if (w_last) r_tag[w_fill_set] <= w_fill_tag;
  end

endmodule

// File: tb/tb_instr_cache_direct.sv
// Scoreboard bench for instr_cache_direct: a line-level cache model predicts hit/miss and data,
// a memory responder serves refills, and a monitor checks beats and completed fetches.
module tb_instr_cache_direct;

  localparam int BEATS = 4;
  localparam int LIMIT = 300;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic        req;
  logic [31:0] rd;
  logic        hit;
  logic        stall;
  logic        inval;
  logic        invalDrv;
  logic        invalResp;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rd;

  assign inval = invalDrv | invalResp;

  instr_cache_direct dut (
    .clk(clock), .reset(reset), .a(a), .req(req), .rd(rd), .hit(hit), .stall(stall),
    .inval(inval), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rd(mem_rd)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          fills;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        txQ[$];
  logic [31:0] beatQ[$];
  bit          mValid[256];
  logic [19:0] mTag[256];
  int          fixedDelay = 0;
  int          invalAtBeat = -1;
  int          beatsDone = 0;

  // Fixed instruction memory contents, any deterministic address hash will do.
  function automatic logic [31:0] memVal(input logic [31:0] addr);
    return 32'hE1A0_0000 ^ {addr[15:0], addr[31:16]} ^ (addr >> 2);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 256; i++) mValid[i] = 1'b0;
  endtask

  // Issue one fetch and hold it until the cache reports a hit.
  task automatic applyStimulus(input logic [31:0] addr, input int invalBeat, input bit sameInval);
    int          set;
    logic [19:0] tag;
    bit          isHit;
    int          fills;
    txn_t        t;
    int          n;
    bit          got;
    set   = int'(addr[11:4]);
    tag   = addr[31:12];
    isHit = mValid[set] && (mTag[set] == tag);
    fills = isHit ? 0 : ((invalBeat >= 0) ? 2 : 1);
    if (sameInval) clearModel();
    if (!isHit && invalBeat >= 0) clearModel();
    if (!isHit) begin
      mValid[set] = 1'b1;
      mTag[set]   = tag;
    end
    for (int f = 0; f < fills; f++)
      for (int i = 0; i < BEATS; i++)
        beatQ.push_back({addr[31:4], 4'h0} + 32'(4 * i));
    t.addr  = addr;
    t.data  = memVal(addr);
    t.fills = fills;
    txQ.push_back(t);
    @(posedge clock); #1;
    a           = addr;
    req         = 1'b1;
    invalDrv    = sameInval;
    invalAtBeat = isHit ? -1 : invalBeat;
    n   = 0;
    got = 1'b0;
    while (!got && n < LIMIT) begin
      @(negedge clock);
      n++;
      if (hit) got = 1'b1;
      else if (n == 1 && invalDrv) begin
        @(posedge clock); #1;
        invalDrv = 1'b0;
      end
    end
    checkOutput("fetchDone", 32'(got), 32'd1);
    @(posedge clock); #1;
    invalDrv    = 1'b0;
    invalAtBeat = -1;
    req         = 1'b0;
  endtask

  task automatic invalIdle();
    @(posedge clock); #1;
    req      = 1'b0;
    invalDrv = 1'b1;
    @(posedge clock); #1;
    invalDrv = 1'b0;
    clearModel();
  endtask

  // Memory responder: acks each beat after a configurable or random number of wait cycles.
  initial begin
    int waitLeft   = -1;
    int beatInFill = 0;
    mem_ack   = 1'b0;
    mem_rd    = '0;
    invalResp = 1'b0;
    forever begin
      @(posedge clock); #1;
      mem_ack   = 1'b0;
      invalResp = 1'b0;
      if (reset) begin
        waitLeft   = -1;
        beatInFill = 0;
      end else if (mem_req) begin
        if (waitLeft < 0) waitLeft = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 2));
        if (waitLeft == 0) begin
          mem_ack = 1'b1;
          mem_rd  = memVal(mem_addr);
          if (invalAtBeat == beatInFill) begin
            invalResp   = 1'b1;
            invalAtBeat = -1;
          end
          beatInFill = (beatInFill + 1) % BEATS;
          beatsDone++;
          waitLeft = -1;
        end else begin
          waitLeft--;
        end
      end
    end
  end

  // Monitor: checks every refill beat address and every completed fetch against the queues.
  initial begin
    int   stallCount = 0;
    int   reqCycles  = 0;
    int   ackCount   = 0;
    txn_t t;
    forever begin
      @(negedge clock);
      if (reset) begin
        stallCount = 0;
        reqCycles  = 0;
        ackCount   = 0;
      end else begin
        if (req && stall) stallCount++;
        if (mem_req) begin
          reqCycles++;
          if (beatQ.size() == 0) checkOutput("memReqIdle", {31'b0, mem_req}, 32'd0);
          else begin
            checkOutput("memAddr", mem_addr, beatQ[0]);
            if (mem_ack) begin
              ackCount++;
              void'(beatQ.pop_front());
            end
          end
        end
        if (req && hit) begin
          if (txQ.size() == 0) checkOutput("hitUnexpected", {31'b0, hit}, 32'd0);
          else begin
            t = txQ.pop_front();
            checkOutput("rdData", rd, t.data);
            checkOutput("stallCycles", 32'(stallCount), 32'(t.fills + reqCycles));
            checkOutput("ackBeats", 32'(ackCount), 32'(t.fills * BEATS));
            stallCount = 0;
            reqCycles  = 0;
            ackCount   = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] addr;
    int          base;
    int          n;
    int          r;
    int          invalBeat;
    bit          sameInval;
    reset    = 1'b1;
    req      = 1'b1;
    a        = 32'h0000_0040;
    invalDrv = 1'b0;
    clearModel();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("resetHit", {31'b0, hit}, 32'd0);
    checkOutput("resetStall", {31'b0, stall}, 32'd1);
    checkOutput("resetMemReq", {31'b0, mem_req}, 32'd0);
    checkOutput("resetMemAddr", mem_addr, 32'd0);
    reset = 1'b0;
    req   = 1'b0;

    fixedDelay = 0;
    applyStimulus(32'h0000_0040, -1, 1'b0);
    applyStimulus(32'h0000_0044, -1, 1'b0);
    applyStimulus(32'h0000_0048, -1, 1'b0);
    applyStimulus(32'h0000_004C, -1, 1'b0);
    applyStimulus(32'h0000_1040, -1, 1'b0);
    applyStimulus(32'h0000_0040, -1, 1'b0);

    fixedDelay = 3;
    applyStimulus(32'h0000_2084, -1, 1'b0);
    fixedDelay = 0;

    applyStimulus(32'h0000_0080, -1, 1'b0);
    invalIdle();
    applyStimulus(32'h0000_0040, -1, 1'b0);
    applyStimulus(32'h0000_0080, -1, 1'b0);

    applyStimulus(32'h0000_3000, 1, 1'b0);
    applyStimulus(32'h0000_3000, -1, 1'b1);
    applyStimulus(32'h0000_3004, -1, 1'b0);
    applyStimulus(32'h0000_6100, -1, 1'b1);

    // Reset in the middle of the third refill beat, then the same fetch must refill from beat 0.
    fixedDelay = 1;
    addr = 32'h0007_5040;
    for (int i = 0; i < BEATS; i++) beatQ.push_back(addr + 32'(4 * i));
    begin
      txn_t t;
      t.addr  = addr;
      t.data  = memVal(addr);
      t.fills = 1;
      txQ.push_back(t);
    end
    @(posedge clock); #1;
    a    = addr;
    req  = 1'b1;
    base = beatsDone;
    n    = 0;
    while (beatsDone < base + 2 && n < LIMIT) begin
      @(negedge clock);
      n++;
    end
    checkOutput("twoBeatsSeen", 32'(beatsDone - base), 32'd2);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    checkOutput("midFillResetMemReq", {31'b0, mem_req}, 32'd0);
    checkOutput("midFillResetHit", {31'b0, hit}, 32'd0);
    checkOutput("midFillResetStall", {31'b0, stall}, 32'd1);
    txQ.delete();
    beatQ.delete();
    clearModel();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    req   = 1'b0;
    applyStimulus(addr, -1, 1'b0);

    fixedDelay = -1;
    for (int k = 0; k < 150; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) invalIdle();
      else begin
        addr = (32'($urandom_range(0, 2)) << 12) | (32'($urandom_range(0, 5)) << 4)
             | (32'($urandom_range(0, 3)) << 2);
        invalBeat = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
        sameInval = ($urandom_range(0, 19) == 0);
        applyStimulus(addr, invalBeat, sameInval);
        repeat ($urandom_range(0, 2)) @(posedge clock);
      end
    end

    repeat (4) @(posedge clock);
    checkOutput("txQueueDrained", 32'(txQ.size()), 32'd0);
    checkOutput("beatQueueDrained", 32'(beatQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
